ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the board's asynchronous cellular RAM between two requesters:
  - a read port (audio playback slice fetch, about 32 kHz);
  - a write port (record/load path).
- Contains arbitration, access timing, the address/data latch and the MemDB tri-state control.
- Replaces ad-hoc direct drive of the RAM control pins.
- Sits between the audio engines and the RAM pins.

Parameters:
- ADDR_W, 23, width of MemAdr and both request addresses.
- DATA_W, 16, data width.
- ACCESS_CYCLES, 7, clk cycles the OE or WE strobe is held (7 cycles = 70 ns at 100 MHz). Legal range 2..15.
- TURN_CYCLES, 1, idle cycles after every access before the next grant. Legal range 1..3.
- STARVE_LIMIT, 4, consecutive read grants allowed while a write is pending.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rd_req  in  1  read request, held until rd_ack
- rd_addr  in  ADDR_W  read address, stable while rd_req is high
- rd_ack  out  1  one-cycle pulse: read granted, address latched
- rd_data  out  DATA_W  captured read word, held until the next read completes
- rd_valid  out  1  one-cycle pulse: rd_data updated
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write word
- wr_ack  out  1  one-cycle pulse: write granted, address and data latched
- wr_done  out  1  one-cycle pulse: write strobe finished
- MemAdr  out  ADDR_W  RAM address, registered
- MemDB  inout  DATA_W  RAM data bus; driven only in WRITE, otherwise Z
- RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB  out  1 each  active-low RAM controls, registered

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE.
  - All seven controls=1.
  - MemDB=Z, MemAdr=0, rd_data=0.
  - All ack, valid and done pulses=0.
  - Starve counter=0, access counter=0.
  - An access in flight is aborted; no rd_valid or wr_done is issued for it.
- Control vector {RamAdv,RamClk,RamCS,MemOE,MemWR,RamLB,RamUB}:
  - IDLE/TURN = 1111111
  - READ = 0000100
  - WRITE = 0001000
- States: IDLE, READ, WRITE, TURN. All outputs are registered.
- IDLE, at a clock edge:
  - Grant rule: if wr_req and (!rd_req or starve==STARVE_LIMIT), grant write. Else if rd_req, grant read. Else stay in IDLE.
  - On a grant: latch address (and data for writes) into MemAdr and the write-data register; set the state; load the strobe controls; pulse the matching ack in the following cycle.
- READ/WRITE:
  - The access counter runs 0..ACCESS_CYCLES-1.
  - At the edge where count==ACCESS_CYCLES-1:
    - READ: capture MemDB into rd_data and pulse rd_valid.
    - WRITE: pulse wr_done.
  - Then go to TURN with idle controls.
  - The MemDB drive is released on the same edge that WE deasserts. No bus drive in TURN.
- TURN: hold for TURN_CYCLES, then return to IDLE.
- Latency:
  - ack is visible 1 cycle after the grant edge.
  - rd_valid/wr_done are visible ACCESS_CYCLES cycles after ack.
  - Minimum grant-to-grant period = ACCESS_CYCLES+TURN_CYCLES+1.
- Starve counter (saturating at STARVE_LIMIT):
  - Increments on each read grant while wr_req=1.
  - Clears on a write grant, or on any edge with wr_req=0.
- Requests that drop before their ack are ignored; no error is raised.
- A request held high after its ack is treated as a new request.
- MemAdr holds its last value between accesses.

Decomposition:
- Package ram_pkg holds:
  - state enum;
  - CTRL_IDLE, CTRL_READ, CTRL_WRITE 7-bit constants;
  - default ACCESS_CYCLES/TURN_CYCLES.
- One sub-module: access_timer. It has a 4-bit down-counter with load and a done flag, and is used for both the strobe phase and the turnaround phase.

Test Plan:
- Single read: rd_req=1, rd_addr=0x00012C, model drives MemDB=0xBEEF while OE=0 -> rd_ack pulses 1 cycle later, controls=0000100 for exactly 7 cycles, rd_valid with rd_data=0xBEEF, then 1 cycle of 1111111.
- Single write: wr_addr=0x05DC00, wr_data=0x1234 -> controls=0001000 for 7 cycles, MemDB=0x1234 throughout, MemDB=Z after, wr_done pulses once, model memory holds 0x1234.
- Simultaneous: rd_req and wr_req held continuously -> grant order R,R,R,R,W,R,R,R,R,W. Grant spacing is 9 cycles.
- Read alone, back-to-back: rd_req held -> an ack every 9 cycles, never a write grant, starve counter stays 0.
- Async reset mid-WRITE, asserted at cycle 3 of the strobe -> controls=1111111 and MemDB=Z without waiting for clk, no wr_done, first grant after release goes through IDLE.
- Request withdrawn: wr_req pulses for 1 cycle while a read is in progress -> no wr_ack, next read is granted normally.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the cellular RAM arbiter.
package ram_pkg;

  // Arbiter phases: waiting for a request, strobing a read or a write,
  // and the idle gap that separates consecutive accesses on the bus.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  // Control pin vector ordering: {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}.
  // All pins are active-low; the idle vector parks every strobe inactive.
  localparam logic [6:0] CTRL_IDLE  = 7'b1111111;
  localparam logic [6:0] CTRL_READ  = 7'b0000100;
  localparam logic [6:0] CTRL_WRITE = 7'b0001000;

  // 7 cycles at 100 MHz gives the 70 ns strobe the RAM needs.
  localparam int DEF_ACCESS_CYCLES = 7;
  localparam int DEF_TURN_CYCLES   = 1;
  localparam int DEF_STARVE_LIMIT  = 4;

endpackage

// File: rtl/ram_arbiter_access_timer.sv
// Small reloadable down-counter used to time both the strobe phase and
// the turnaround gap. done is high whenever the count has reached zero.
module access_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count_reg;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != 4'd0) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign done = (count_reg == 4'd0);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the asynchronous cellular RAM: a read port for audio
// playback fetches and a write port for the record/load path. It owns the
// address/data latches, strobe timing and the MemDB tri-state enable.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W        = 23,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_done,
  output logic [ADDR_W-1:0] MemAdr,
  inout  wire  [DATA_W-1:0] MemDB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  // The timer counts down to zero, so it is loaded with length-1.
  localparam logic [3:0] STROBE_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [6:0]          ctrl_reg, ctrl_next;
  logic [ADDR_W-1:0]   mem_adr_reg, mem_adr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                drive_reg, drive_next;
  logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
  logic                rd_ack_reg, rd_ack_next;
  logic                wr_ack_reg, wr_ack_next;
  logic                rd_valid_reg, rd_valid_next;
  logic                wr_done_reg, wr_done_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;

  logic       write_wins;
  logic       grant_wr;
  logic       grant_rd;
  logic       strobe_end;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_done;

  access_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Writes only win against a concurrent read once the reader has had its
  // quota of consecutive grants; otherwise playback gets priority.
  assign write_wins = wr_req && (!rd_req || (starve_reg == STARVE_MAX));
  assign grant_wr   = (state_reg == ST_IDLE) && write_wins;
  assign grant_rd   = (state_reg == ST_IDLE) && !write_wins && rd_req;
  assign strobe_end = ((state_reg == ST_READ) || (state_reg == ST_WRITE)) && tmr_done;

  // State and every output are registered; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      ctrl_reg     <= CTRL_IDLE;
      mem_adr_reg  <= '0;
      wdata_reg    <= '0;
      drive_reg    <= 1'b0;
      rd_data_reg  <= '0;
      rd_ack_reg   <= 1'b0;
      wr_ack_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      wr_done_reg  <= 1'b0;
      starve_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      mem_adr_reg  <= mem_adr_next;
      wdata_reg    <= wdata_next;
      drive_reg    <= drive_next;
      rd_data_reg  <= rd_data_next;
      rd_ack_reg   <= rd_ack_next;
      wr_ack_reg   <= wr_ack_next;
      rd_valid_reg <= rd_valid_next;
      wr_done_reg  <= wr_done_next;
      starve_reg   <= starve_next;
    end
  end

  // Next-state logic: grant from IDLE, leave the strobe when the timer
  // expires, and hold the turnaround gap before accepting another grant.
  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = 4'd0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_wr) begin
          state_next = ST_WRITE;
          tmr_load   = 1'b1;
          tmr_val    = STROBE_LOAD;
        end else if (grant_rd) begin
          state_next = ST_READ;
          tmr_load   = 1'b1;
          tmr_val    = STROBE_LOAD;
        end
      end
      ST_READ, ST_WRITE: begin
        if (tmr_done) begin
          state_next = ST_TURN;
          tmr_load   = 1'b1;
          tmr_val    = TURN_LOAD;
        end
      end
      ST_TURN: begin
        if (tmr_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: latch address/data and strobes on a grant, close the
  // strobe and release the bus together, and keep the starve count.
  always_comb begin
    ctrl_next     = ctrl_reg;
    mem_adr_next  = mem_adr_reg;
    wdata_next    = wdata_reg;
    drive_next    = drive_reg;
    rd_data_next  = rd_data_reg;
    rd_ack_next   = 1'b0;
    wr_ack_next   = 1'b0;
    rd_valid_next = 1'b0;
    wr_done_next  = 1'b0;
    starve_next   = starve_reg;

    if (grant_wr) begin
      ctrl_next    = CTRL_WRITE;
      mem_adr_next = wr_addr;
      wdata_next   = wr_data;
      drive_next   = 1'b1;
      wr_ack_next  = 1'b1;
    end else if (grant_rd) begin
      ctrl_next    = CTRL_READ;
      mem_adr_next = rd_addr;
      rd_ack_next  = 1'b1;
    end

    if (strobe_end) begin
      ctrl_next  = CTRL_IDLE;
      drive_next = 1'b0;
      if (state_reg == ST_READ) begin
        rd_data_next  = MemDB;
        rd_valid_next = 1'b1;
      end else begin
        wr_done_next = 1'b1;
      end
    end

    // Only reads granted over a waiting write count toward starvation.
    if (!wr_req || grant_wr) begin
      starve_next = '0;
    end else if (grant_rd && (starve_reg != STARVE_MAX)) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  assign MemDB    = drive_reg ? wdata_reg : {DATA_W{1'bz}};
  assign MemAdr   = mem_adr_reg;
  assign rd_data  = rd_data_reg;
  assign rd_ack   = rd_ack_reg;
  assign wr_ack   = wr_ack_reg;
  assign rd_valid = rd_valid_reg;
  assign wr_done  = wr_done_reg;
  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM device model on the pins, a transaction-level
// reference (grant times, starve count, reference memory) checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_arbiter;

  localparam int ACC = 7;
  localparam int TRN = 1;
  localparam int LIM = 4;
  localparam int PERIOD = ACC + TRN + 1;
  localparam logic [6:0]  C_IDLE = 7'b1111111;
  localparam logic [6:0]  C_RD   = 7'b0000100;
  localparam logic [6:0]  C_WR   = 7'b0001000;
  // Value the device parks on the bus when no strobe is active; a leaking
  // controller drive corrupts it.
  localparam logic [15:0] PROBE  = 16'hC3A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [22:0] rd_addr = '0;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_req = 1'b0;
  logic [22:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        wr_done;
  logic [22:0] MemAdr;
  wire  [15:0] MemDB;
  logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
  wire  [6:0]  ctrl = {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB};

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
    .MemAdr(MemAdr), .MemDB(MemDB),
    .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS), .MemOE(MemOE), .MemWR(MemWR),
    .RamLB(RamLB), .RamUB(RamUB)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %s, required %s (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] init_val(input logic [9:0] a);
    if (a == 10'h12C) return 16'hBEEF;
    return {a[5:0], a} ^ 16'h5A5A;
  endfunction

  // ---------------- RAM device on the pins (1K words, address aliased) -----
  logic [15:0] dev_mem [1024];
  bit          dev_init_done = 1'b0;
  logic        dev_en;
  logic [15:0] dev_val;

  always_comb begin
    dev_en  = 1'b0;
    dev_val = PROBE;
    if (!MemOE && !RamCS) begin
      dev_en  = 1'b1;
      dev_val = dev_mem[MemAdr[9:0]];
    end else if (ctrl == C_IDLE) begin
      dev_en = 1'b1;
    end
  end

  assign MemDB = dev_en ? dev_val : 16'bz;

  always @(negedge clk) begin
    if (!dev_init_done) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= init_val(10'(i));
      dev_init_done <= 1'b1;
    end else if (!MemWR && !RamCS) begin
      dev_mem[MemAdr[9:0]] <= MemDB;
    end
  end

  // ---------------- Reference model: grants as timed transactions ----------
  logic [15:0] ref_mem [1024];
  bit          ref_init = 1'b0;
  int          cyc = 0;
  int          act_cyc = 0;
  int          free_cyc = 0;
  int          starve = 0;
  bit          act_v = 1'b0;
  bit          act_w = 1'b0;
  logic [15:0] act_d = '0;
  logic [22:0] act_a = '0;
  logic [22:0] exp_adr = '0;
  logic [15:0] exp_rdata = '0;

  always @(posedge clk or negedge rst) begin
    bit wg;
    if (!rst) begin
      act_v = 1'b0; free_cyc = 0; starve = 0; exp_adr = '0; exp_rdata = '0;
      if (!ref_init) begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));
        ref_init = 1'b1;
      end
    end else begin
      cyc++;
      if (act_v && !act_w && (cyc - act_cyc == ACC)) exp_rdata = ref_mem[act_a[9:0]];
      if (cyc >= free_cyc) begin
        wg = wr_req && (!rd_req || starve == LIM);
        if (wg) begin
          act_v = 1'b1; act_w = 1'b1; act_a = wr_addr; act_d = wr_data; act_cyc = cyc;
          free_cyc = cyc + PERIOD; exp_adr = wr_addr; ref_mem[wr_addr[9:0]] = wr_data;
          starve = 0;
        end else if (rd_req) begin
          act_v = 1'b1; act_w = 1'b0; act_a = rd_addr; act_cyc = cyc;
          free_cyc = cyc + PERIOD; exp_adr = rd_addr;
          if (wr_req && starve < LIM) starve++;
        end
      end
      if (!wr_req) starve = 0;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    int  d;
    bit  strobe;
    logic [6:0] exp_ctrl;
    if (chk_en && rst) begin
      d        = cyc - act_cyc;
      strobe   = act_v && (d < ACC);
      exp_ctrl = strobe ? (act_w ? C_WR : C_RD) : C_IDLE;
      chk("ctrl", 32'(ctrl), 32'(exp_ctrl));
      chk("MemAdr", 32'(MemAdr), 32'(exp_adr));
      chk("rd_ack", 32'(rd_ack), 32'(act_v && !act_w && d == 0));
      chk("wr_ack", 32'(wr_ack), 32'(act_v && act_w && d == 0));
      chk("rd_valid", 32'(rd_valid), 32'(act_v && !act_w && d == ACC));
      chk("wr_done", 32'(wr_done), 32'(act_v && act_w && d == ACC));
      chk("rd_data", 32'(rd_data), 32'(exp_rdata));
      if (strobe && act_w) chk("MemDB_write", 32'(MemDB), 32'(act_d));
      else if (!strobe)    chk("MemDB_idle", 32'(MemDB), 32'(PROBE));
    end
  end

  task automatic wait_ack(input bit wr, output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (wr ? wr_ack : rd_ack) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n, cnt, last, gi, wr_seen, done_seen;
    bit    ok;
    string order;

    // ---- reset ----
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("reset_MemAdr", 32'(MemAdr), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_pulses", 32'({rd_ack, wr_ack, rd_valid, wr_done}), 32'h0);
    chk("reset_MemDB", 32'(MemDB), 32'(PROBE));
    chk_en = 1'b1;

    // ---- single read ----
    rd_addr = 23'h00012C; rd_req = 1'b1;
    wait_ack(1'b0, n, ok);
    rd_req = 1'b0;
    chk("rd_ack_seen", 32'(ok), 32'h1);
    chk("rd_ack_latency", 32'(n), 32'd1);
    cnt = 0;
    for (int i = 0; i < 30 && ctrl == C_RD; i++) begin cnt++; @(negedge clk); end
    chk("rd_strobe_cycles", 32'(cnt), 32'd7);
    chk("rd_valid_at_end", 32'(rd_valid), 32'h1);
    chk("rd_data_beef", 32'(rd_data), 32'hBEEF);
    @(negedge clk);
    chk("rd_turn_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("rd_valid_one_cycle", 32'(rd_valid), 32'h0);
    repeat (2) @(negedge clk);

    // ---- single write ----
    wr_addr = 23'h05DC00; wr_data = 16'h1234; wr_req = 1'b1;
    wait_ack(1'b1, n, ok);
    wr_req = 1'b0;
    chk("wr_ack_seen", 32'(ok), 32'h1);
    chk("wr_ack_latency", 32'(n), 32'd1);
    cnt = 0;
    for (int i = 0; i < 30 && ctrl == C_WR; i++) begin
      chk("wr_bus_1234", 32'(MemDB), 32'h1234);
      cnt++;
      @(negedge clk);
    end
    chk("wr_strobe_cycles", 32'(cnt), 32'd7);
    chk("wr_done_at_end", 32'(wr_done), 32'h1);
    chk("wr_bus_released", 32'(MemDB), 32'(PROBE));
    @(negedge clk);
    chk("wr_done_one_cycle", 32'(wr_done), 32'h0);
    chk("wr_mem_holds", 32'(dev_mem[10'h000]), 32'h1234);
    repeat (2) @(negedge clk);

    // ---- simultaneous requests: starvation cap lets a write in every 5th ----
    rd_addr = 23'($urandom); wr_addr = 23'($urandom); wr_data = 16'($urandom);
    rd_req = 1'b1; wr_req = 1'b1;
    order = ""; last = -1;
    for (int i = 0; i < 200 && order.len() < 10; i++) begin
      @(negedge clk);
      if (rd_ack || wr_ack) begin
        if (last >= 0) chk("sim_grant_spacing", 32'(i - last), 32'(PERIOD));
        last = i;
      end
      if (rd_ack) begin order = {order, "R"}; rd_addr = 23'($urandom); end
      if (wr_ack) begin order = {order, "W"}; wr_addr = 23'($urandom); wr_data = 16'($urandom); end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk_str("sim_grant_order", order, "RRRRWRRRRW");
    repeat (12) @(negedge clk);

    // ---- back-to-back reads only ----
    rd_addr = 23'($urandom); rd_req = 1'b1;
    gi = 0; last = -1; wr_seen = 0;
    for (int i = 0; i < 120 && gi < 5; i++) begin
      @(negedge clk);
      if (wr_ack) wr_seen++;
      if (rd_ack) begin
        if (last >= 0) chk("b2b_spacing", 32'(i - last), 32'(PERIOD));
        last = i; gi++; rd_addr = 23'($urandom);
      end
    end
    rd_req = 1'b0;
    chk("b2b_grants", 32'(gi), 32'd5);
    chk("b2b_no_write", 32'(wr_seen), 32'd0);
    repeat (12) @(negedge clk);

    // ---- write request withdrawn during a read ----
    rd_addr = 23'($urandom); rd_req = 1'b1;
    wait_ack(1'b0, n, ok);
    chk("wd_first_ack", 32'(ok), 32'h1);
    rd_req = 1'b0;
    @(negedge clk);
    wr_addr = 23'($urandom); wr_data = 16'($urandom); wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0; rd_addr = 23'($urandom); rd_req = 1'b1;
    wr_seen = 0; ok = 1'b0; cnt = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (wr_ack) wr_seen++;
      if (rd_ack) begin ok = 1'b1; break; end
    end
    rd_req = 1'b0;
    chk("wd_next_read", 32'(ok), 32'h1);
    chk("wd_read_spacing", 32'(cnt), 32'(PERIOD));
    chk("wd_no_wr_ack", 32'(wr_seen), 32'd0);
    repeat (12) @(negedge clk);

    // ---- asynchronous reset in the middle of a write strobe ----
    wr_addr = 23'($urandom); wr_data = 16'h0F0F; wr_req = 1'b1;
    wait_ack(1'b1, n, ok);
    wr_req = 1'b0;
    chk("ar_wr_ack", 32'(ok), 32'h1);
    repeat (2) @(negedge clk);           // now in strobe cycle 3
    chk("ar_in_write", 32'(ctrl), 32'(C_WR));
    #2 rst = 1'b0;
    #1;
    chk("ar_ctrl_immediate", 32'(ctrl), 32'(C_IDLE));
    chk("ar_bus_immediate", 32'(MemDB), 32'(PROBE));
    done_seen = 0;
    repeat (3) begin @(negedge clk); if (wr_done) done_seen++; end
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (wr_done) done_seen++; end
    chk("ar_no_wr_done", 32'(done_seen), 32'd0);
    rd_addr = 23'($urandom); rd_req = 1'b1;
    wait_ack(1'b0, n, ok);
    rd_req = 1'b0;
    chk("ar_read_after", 32'(ok), 32'h1);
    chk("ar_read_latency", 32'(n), 32'd1);
    repeat (12) @(negedge clk);

    // ---- random traffic against the model ----
    fork
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          if (rd_req) begin
            if (rd_ack) begin
              if ($urandom_range(0, 3) == 0) rd_addr = 23'($urandom);
              else rd_req = 1'b0;
            end else if ($urandom_range(0, 31) == 0) begin
              rd_req = 1'b0;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            rd_req = 1'b1; rd_addr = 23'($urandom);
          end
        end
        rd_req = 1'b0;
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          if (wr_req) begin
            if (wr_ack) begin
              if ($urandom_range(0, 3) == 0) begin wr_addr = 23'($urandom); wr_data = 16'($urandom); end
              else wr_req = 1'b0;
            end else if ($urandom_range(0, 31) == 0) begin
              wr_req = 1'b0;
            end
          end else if ($urandom_range(0, 4) == 0) begin
            wr_req = 1'b1; wr_addr = 23'($urandom); wr_data = 16'($urandom);
          end
        end
        wr_req = 1'b0;
      end
    join
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
